// File: rtl/fp_mul_seq_if.sv
// Start/done handshake bundle between the ALU master and the sequential FP multiplier.
interface fp_mul_seq_if;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        exception;

  modport master (output A, B, start, input busy, done, out, exception);
  modport slave  (input A, B, start, output busy, done, out, exception);
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 single-precision multiplier: shift-and-add mantissa product, one bit per clock.
// Define FPMUL_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates toward zero.
module fp_mul_seq (
  input logic         clk,
  input logic         reset,
  fp_mul_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MULT, NORM} state_t;

  state_t       state_q, state_d;
  logic         sign_q, sign_d;
  logic [7:0]   expa_q, expa_d, expb_q, expb_d;
  logic [23:0]  mcand_q, mcand_d, mplier_q, mplier_d;
  logic [47:0]  prod_q, prod_d;
  logic [4:0]   cnt_q, cnt_d;
  logic [31:0]  out_q, out_d;
  logic         exc_q, exc_d, done_q, done_d;

  logic signed [9:0] exp_base, exp_fin;
  logic [22:0]       mant_raw, mant_fin;
  logic [23:0]       mant_inc;
  logic              rnd_up;
`ifdef FPMUL_ROUND_NEAREST_EN
  logic              guard, sticky;
`endif

  // Normalisation and rounding of the finished product; only consumed in NORM.
  always_comb begin
    exp_base = $signed({2'b00, expa_q} + {2'b00, expb_q} - 10'd127);
    if (prod_q[47]) begin
      mant_raw = prod_q[46:24];
      exp_fin  = exp_base + 10'sd1;
    end else begin
      mant_raw = prod_q[45:23];
      exp_fin  = exp_base;
    end
`ifdef FPMUL_ROUND_NEAREST_EN
    guard  = prod_q[47] ? prod_q[23] : prod_q[22];
    sticky = prod_q[47] ? (|prod_q[22:0]) : (|prod_q[21:0]);
    rnd_up = guard & (sticky | mant_raw[0]);
`else
    rnd_up = 1'b0;
`endif
    mant_inc = {1'b0, mant_raw} + {23'b0, rnd_up};
    if (mant_inc[23]) begin
      mant_fin = 23'b0;
      exp_fin  = exp_fin + 10'sd1;
    end else begin
      mant_fin = mant_inc[22:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    expa_d   = expa_q;
    expb_d   = expb_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    exc_d    = exc_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d   = bus.A[31] ^ bus.B[31];
          expa_d   = bus.A[30:23];
          expb_d   = bus.B[30:23];
          mcand_d  = {1'b1, bus.A[22:0]};
          mplier_d = {1'b1, bus.B[22:0]};
          prod_d   = 48'b0;
          cnt_d    = 5'd0;
          state_d  = MULT;
        end
      end
      MULT: begin
        if (mplier_q[0]) prod_d = prod_q + ({24'b0, mcand_q} << cnt_q);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = NORM;
      end
      NORM: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (expa_q == 8'hFF || expb_q == 8'hFF) begin
          out_d = {sign_q, 8'hFF, 23'b0};
          exc_d = 1'b1;
        end else if (expa_q == 8'h00 || expb_q == 8'h00) begin
          out_d = {sign_q, 31'b0};
          exc_d = 1'b0;
        end else if (exp_fin >= 10'sd255) begin
          out_d = {sign_q, 8'hFF, 23'b0};
          exc_d = 1'b1;
        end else if (exp_fin <= 10'sd0) begin
          out_d = {sign_q, 31'b0};
          exc_d = 1'b1;
        end else begin
          out_d = {sign_q, exp_fin[7:0], mant_fin};
          exc_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      expa_q   <= 8'b0;
      expb_q   <= 8'b0;
      mcand_q  <= 24'b0;
      mplier_q <= 24'b0;
      prod_q   <= 48'b0;
      cnt_q    <= 5'd0;
      out_q    <= 32'b0;
      exc_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      expa_q   <= expa_d;
      expb_q   <= expb_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      exc_q    <= exc_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.out       = out_q;
  assign bus.exception = exc_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed spec vectors, randomized operands against a
// behavioural reference, and handshake/reset timing scenarios.
module tb_fp_mul_seq;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  fp_mul_seq_if bus ();
  fp_mul_seq dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer mantissa product, then the specified normalise/round/range rules.
  function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    logic        g, st;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) return {1'b1, s, 8'hFF, 23'b0};
    if (ea == 0 || eb == 0) return {1'b0, s, 31'b0};
    p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24]; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = p[45:23]; g = p[22]; st = |p[21:0];
    end
`ifdef FPMUL_ROUND_NEAREST_EN
    if (g && (st || m[0])) begin
      if (m == 23'h7FFFFF) begin
        m = 23'b0; e = e + 1;
      end else begin
        m = m + 23'd1;
      end
    end
`else
    if (g && st) m = m;
`endif
    if (e >= 255) return {1'b1, s, 8'hFF, 23'b0};
    if (e <= 0) return {1'b1, s, 31'b0};
    return {1'b0, s, e[7:0], m};
  endfunction

  // Single operation from an idle DUT; checks latency, busy window, result and done width.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp,
                       input string tag);
    int lat = 0;
    int nbusy = 0;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A = $urandom; bus.B = $urandom;
    if (bus.busy) nbusy++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (bus.busy) nbusy++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd25);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd25);
    chk({tag, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_out"}, bus.out, exp[31:0]);
    chk({tag, "_exc"}, {31'b0, bus.exception}, {31'b0, exp[32]});
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    int          dq[$];
    logic [31:0] ra, rb, held_out;
    logic [32:0] rexp;

    reset = 1'b1; bus.start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", bus.out, 32'd0);
    chk("rst_exc", {31'b0, bus.exception}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk); reset = 1'b0;

    do_op(32'h40000000, 32'h40400000, {1'b0, 32'h40C00000}, "two_x_three");
    do_op(32'hBFC00000, 32'h40200000, {1'b0, 32'hC0700000}, "neg_mul");
    do_op(32'h00000000, 32'h7F000000, {1'b0, 32'h00000000}, "zero_op");
    do_op(32'h7F000000, 32'h7F000000, {1'b1, 32'h7F800000}, "overflow");
    do_op(32'h00800000, 32'h00800000, {1'b1, 32'h00000000}, "underflow");
    do_op(32'h7FC00000, 32'h3F800000, {1'b1, 32'h7F800000}, "nan_op");
`ifdef FPMUL_ROUND_NEAREST_EN
    do_op(32'h3F800001, 32'h3FC00000, {1'b0, 32'h3FC00002}, "round_tie");
`else
    do_op(32'h3F800001, 32'h3FC00000, {1'b0, 32'h3FC00001}, "round_tie");
`endif

    for (int n = 0; n < 16; n++) begin
      ra = $urandom; rb = $urandom;
      if (n < 12) begin
        ra[30:23] = 8'($urandom_range(90, 165));
        rb[30:23] = 8'($urandom_range(90, 165));
      end
      rexp = ref_mul(ra, rb);
      do_op(ra, rb, rexp, $sformatf("rand%0d", n));
    end

    // start held high: accepts only every 26 edges
    dq.delete();
    for (int k = 0; k <= 78; k++) begin
      @(negedge clk);
      bus.start = 1'b1; bus.A = 32'h40000000; bus.B = 32'h40400000;
      @(posedge clk); #1;
      if (bus.done) dq.push_back(k);
    end
    chk("hold_done_count", 32'(dq.size()), 32'd3);
    chk("hold_done0", 32'(dq.size() > 0 ? dq[0] : -1), 32'd25);
    chk("hold_done1", 32'(dq.size() > 1 ? dq[1] : -1), 32'd51);
    chk("hold_done2", 32'(dq.size() > 2 ? dq[2] : -1), 32'd77);
    chk("hold_out", bus.out, 32'h40C00000);
    chk("hold_busy_reaccept", {31'b0, bus.busy}, 32'd1);
    @(negedge clk); bus.start = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;

    // second start during the operation is ignored
    dq.delete();
    held_out = 32'hDEADBEEF;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      bus.start = (k == 0 || k == 10);
      bus.A = (k == 0) ? 32'h3FC00000 : 32'h40A00000;
      bus.B = (k == 0) ? 32'h40000000 : 32'h41200000;
      @(posedge clk); #1;
      if (bus.done) begin
        dq.push_back(k);
        held_out = bus.out;
      end
    end
    chk("ignore_done_count", 32'(dq.size()), 32'd1);
    chk("ignore_done_edge", 32'(dq.size() > 0 ? dq[0] : -1), 32'd25);
    chk("ignore_out", held_out, 32'h40400000);

    // reset mid-operation, then a fresh start two edges later
    dq.delete();
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      bus.start = (k == 0 || k == 14);
      reset = (k == 12);
      bus.A = (k == 0) ? 32'h3FC00000 : 32'h40000000;
      bus.B = (k == 0) ? 32'h40000000 : 32'h40400000;
      @(posedge clk); #1;
      if (bus.done) dq.push_back(k);
      if (k == 12) begin
        chk("midrst_out", bus.out, 32'd0);
        chk("midrst_busy", {31'b0, bus.busy}, 32'd0);
        chk("midrst_exc", {31'b0, bus.exception}, 32'd0);
      end
    end
    chk("midrst_done_count", 32'(dq.size()), 32'd1);
    chk("midrst_done_edge", 32'(dq.size() > 0 ? dq[0] : -1), 32'd39);
    chk("midrst_new_out", bus.out, 32'h40C00000);

    // reset and start together: request dropped
    @(negedge clk); reset = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1;
    chk("rst_start_busy0", {31'b0, bus.busy}, 32'd0);
    @(negedge clk); reset = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rst_start_busy1", {31'b0, bus.busy}, 32'd0);
    chk("rst_start_out", bus.out, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
